// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder
//
// Turns the byte stream from a PS/2 receiver into Set-2 key events in the
// clk domain. It handles the receiver handshake, the E0 (extended) and F0
// (break) prefixes, and prefix timeout. It also tracks the jump key as a held
// level plus a de-repeated press pulse.
//
// Ports
//   clk            in   system clock
//   rst            in   synchronous active-high reset
//   received       in   byte-ready flag from the receiver (asynchronous to clk)
//   received_data  in   received byte, stable while received is high
//   read_ack       out  acknowledge level back to the receiver
//   key_valid      out  one-cycle pulse per emitted key event
//   key_code       out  scan code of the last event (held)
//   key_extended   out  last event was E0-prefixed (held)
//   key_break      out  last event was a release (held)
//   jump_held      out  jump key currently down
//   jump_press     out  one-cycle pulse on a fresh jump key press
//   proto_err      out  one-cycle pulse on an illegal sequence or error code
module ps2_scancode_decoder #(
   parameter logic [7:0] JUMP_CODE      = 8'h29,
   parameter int         SYNC_STAGES    = 2,
   parameter int         TIMEOUT_CYCLES = 2_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       received,
   input  logic [7:0] received_data,
   output logic       read_ack,
   output logic       key_valid,
   output logic [7:0] key_code,
   output logic       key_extended,
   output logic       key_break,
   output logic       jump_held,
   output logic       jump_press,
   output logic       proto_err
);

   localparam int              TW       = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_E0, ST_F0, ST_E0F0} state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [SYNC_STAGES-1:0] fill_q, fill_d;
   logic                   rcv_d_q, rcv_d_d;
   logic                   armed_q, armed_d;
   logic [7:0]             byte_q, byte_d;
   logic                   pending_q, pending_d;
   logic                   read_ack_q, read_ack_d;
   logic [TW-1:0]          tmo_q, tmo_d;
   logic                   key_valid_q, key_valid_d;
   logic [7:0]             key_code_q, key_code_d;
   logic                   key_ext_q, key_ext_d;
   logic                   key_brk_q, key_brk_d;
   logic                   jump_held_q, jump_held_d;
   logic                   jump_press_q, jump_press_d;
   logic                   proto_err_q, proto_err_d;

   logic rcv_s;
   logic capture;
   logic is_err_code;
   logic emit, emit_ext, emit_brk;

   // Capture path. fill_q marks when rcv_s holds a genuine post-reset sample:
   // the sync flops reset to 0, which would otherwise look like "received low"
   // and arm capture while received is actually stuck high across reset.
   always_comb begin
      sync_d      = {sync_q[SYNC_STAGES-2:0], received};
      fill_d      = {fill_q[SYNC_STAGES-2:0], 1'b1};
      rcv_s       = sync_q[SYNC_STAGES-1];
      rcv_d_d     = rcv_s;
      armed_d     = armed_q | (fill_q[SYNC_STAGES-1] & ~rcv_s);
      capture     = armed_q & rcv_s & ~rcv_d_q;
      byte_d      = capture ? received_data : byte_q;
      pending_d   = capture;
      read_ack_d  = read_ack_q;
      if (capture) begin
         read_ack_d = 1'b1;
      end else if (!rcv_s) begin
         read_ack_d = 1'b0;
      end
   end

   // Prefix FSM, event generation, jump tracking and prefix timeout. A byte
   // being decoded takes priority over the timeout; a capture on the timeout
   // edge also suppresses it, since the counter restarts on every capture.
   always_comb begin
      state_d      = state_q;
      key_valid_d  = 1'b0;
      key_code_d   = key_code_q;
      key_ext_d    = key_ext_q;
      key_brk_d    = key_brk_q;
      jump_held_d  = jump_held_q;
      jump_press_d = 1'b0;
      proto_err_d  = 1'b0;
      emit         = 1'b0;
      emit_ext     = 1'b0;
      emit_brk     = 1'b0;
      is_err_code  = (byte_q == 8'h00) || (byte_q == 8'hFF);

      if (pending_q) begin
         case (state_q)
            ST_IDLE: begin
               if (byte_q == 8'hE0) begin
                  state_d = ST_E0;
               end else if (byte_q == 8'hF0) begin
                  state_d = ST_F0;
               end else if (is_err_code) begin
                  proto_err_d = 1'b1;
               end else if ((byte_q == 8'hAA) || (byte_q == 8'hFA) ||
                            (byte_q == 8'hFE) || (byte_q == 8'hEE)) begin
                  state_d = ST_IDLE;
               end else begin
                  emit = 1'b1;
               end
            end
            ST_E0: begin
               if (byte_q == 8'hF0) begin
                  state_d = ST_E0F0;
               end else if (byte_q == 8'hE0) begin
                  state_d = ST_E0;
               end else if (is_err_code) begin
                  proto_err_d = 1'b1;
                  state_d     = ST_IDLE;
               end else begin
                  emit     = 1'b1;
                  emit_ext = 1'b1;
                  state_d  = ST_IDLE;
               end
            end
            ST_F0, ST_E0F0: begin
               state_d = ST_IDLE;
               if (is_err_code || (byte_q == 8'hE0) || (byte_q == 8'hF0)) begin
                  proto_err_d = 1'b1;
               end else begin
                  emit     = 1'b1;
                  emit_ext = (state_q == ST_E0F0);
                  emit_brk = 1'b1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end else if ((state_q != ST_IDLE) && !capture && (tmo_q == TMO_LAST)) begin
         state_d = ST_IDLE;
      end

      if (emit) begin
         key_valid_d = 1'b1;
         key_code_d  = byte_q;
         key_ext_d   = emit_ext;
         key_brk_d   = emit_brk;
         if (!emit_ext && (byte_q == JUMP_CODE)) begin
            if (emit_brk) begin
               jump_held_d = 1'b0;
            end else begin
               jump_held_d  = 1'b1;
               jump_press_d = ~jump_held_q;
            end
         end
      end

      if (capture || (state_d == ST_IDLE)) begin
         tmo_d = '0;
      end else if (state_q != ST_IDLE) begin
         tmo_d = tmo_q + TW'(1);
      end else begin
         tmo_d = tmo_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         sync_q       <= '0;
         fill_q       <= '0;
         rcv_d_q      <= 1'b0;
         armed_q      <= 1'b0;
         byte_q       <= '0;
         pending_q    <= 1'b0;
         read_ack_q   <= 1'b0;
         tmo_q        <= '0;
         key_valid_q  <= 1'b0;
         key_code_q   <= '0;
         key_ext_q    <= 1'b0;
         key_brk_q    <= 1'b0;
         jump_held_q  <= 1'b0;
         jump_press_q <= 1'b0;
         proto_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         sync_q       <= sync_d;
         fill_q       <= fill_d;
         rcv_d_q      <= rcv_d_d;
         armed_q      <= armed_d;
         byte_q       <= byte_d;
         pending_q    <= pending_d;
         read_ack_q   <= read_ack_d;
         tmo_q        <= tmo_d;
         key_valid_q  <= key_valid_d;
         key_code_q   <= key_code_d;
         key_ext_q    <= key_ext_d;
         key_brk_q    <= key_brk_d;
         jump_held_q  <= jump_held_d;
         jump_press_q <= jump_press_d;
         proto_err_q  <= proto_err_d;
      end
   end

   assign read_ack     = read_ack_q;
   assign key_valid    = key_valid_q;
   assign key_code     = key_code_q;
   assign key_extended = key_ext_q;
   assign key_break    = key_brk_q;
   assign jump_held    = jump_held_q;
   assign jump_press   = jump_press_q;
   assign proto_err    = proto_err_q;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// tb_ps2_scancode_decoder
//
// Directed testbench for ps2_scancode_decoder. Stimulus pushes the expected
// event (or protocol error) into a queue; a monitor pops and compares whenever
// the design pulses key_valid or proto_err.
module tb_ps2_scancode_decoder;

   localparam int SYNC   = 2;
   localparam int TMO    = 20;
   localparam int BOUND  = 30;

   typedef struct packed {
      logic       err;
      logic [7:0] code;
      logic       ext;
      logic       brk;
      logic       press;
      logic       held;
   } exp_t;

   logic       clk;
   logic       rst;
   logic       received;
   logic [7:0] received_data;
   logic       read_ack;
   logic       key_valid;
   logic [7:0] key_code;
   logic       key_extended;
   logic       key_break;
   logic       jump_held;
   logic       jump_press;
   logic       proto_err;

   int   assertCount = 0;
   int   failCount   = 0;
   exp_t expQ[$];

   ps2_scancode_decoder #(
      .JUMP_CODE      (8'h29),
      .SYNC_STAGES    (SYNC),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .received      (received),
      .received_data (received_data),
      .read_ack      (read_ack),
      .key_valid     (key_valid),
      .key_code      (key_code),
      .key_extended  (key_extended),
      .key_break     (key_break),
      .jump_held     (jump_held),
      .jump_press    (jump_press),
      .proto_err     (proto_err)
   );

   // 10 ns system clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case a wait ever escapes its bound
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Single comparison point; every check goes through here
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic pushEvent(input logic [7:0] code, input logic ext, input logic brk,
                            input logic press, input logic held);
      exp_t e;
      e = '{err: 1'b0, code: code, ext: ext, brk: brk, press: press, held: held};
      expQ.push_back(e);
   endtask

   task automatic pushErr();
      exp_t e;
      e = '{err: 1'b1, code: 8'h00, ext: 1'b0, brk: 1'b0, press: 1'b0, held: 1'b0};
      expQ.push_back(e);
   endtask

   // Full handshake for one byte: raise received, wait for read_ack, drop,
   // wait for read_ack to clear, then leave a few idle cycles
   task automatic applyStimulus(input logic [7:0] b);
      int n;
      @(negedge clk);
      received_data = b;
      received      = 1'b1;
      n = 0;
      while (!read_ack && n < BOUND) begin
         @(negedge clk);
         n++;
      end
      checkOutput("read_ack_rise", read_ack, 1);
      received = 1'b0;
      n = 0;
      while (read_ack && n < BOUND) begin
         @(negedge clk);
         n++;
      end
      checkOutput("read_ack_fall", read_ack, 0);
      repeat (3) @(negedge clk);
   endtask

   task automatic doReset(input int cycles);
      @(negedge clk);
      rst = 1'b1;
      repeat (cycles) @(negedge clk);
      rst = 1'b0;
   endtask

   // Scoreboard monitor: compare every key event or protocol error against
   // the head of the expectation queue
   always @(negedge clk) begin : monitor
      exp_t e;
      if (!rst && (key_valid || proto_err)) begin
         if (expQ.size() == 0) begin
            checkOutput("unexpected_output", {key_valid, proto_err}, 0);
         end else begin
            e = expQ.pop_front();
            checkOutput("proto_err", proto_err, e.err);
            checkOutput("key_valid", key_valid, !e.err);
            if (!e.err) begin
               checkOutput("key_code", key_code, e.code);
               checkOutput("key_extended", key_extended, e.ext);
               checkOutput("key_break", key_break, e.brk);
               checkOutput("jump_press", jump_press, e.press);
               checkOutput("jump_held", jump_held, e.held);
            end
         end
      end
   end

   initial begin
      rst           = 1'b1;
      received      = 1'b0;
      received_data = 8'h00;
      repeat (3) @(negedge clk);

      // Reset state
      checkOutput("rst_read_ack", read_ack, 0);
      checkOutput("rst_key_valid", key_valid, 0);
      checkOutput("rst_key_code", key_code, 0);
      checkOutput("rst_key_extended", key_extended, 0);
      checkOutput("rst_key_break", key_break, 0);
      checkOutput("rst_jump_held", jump_held, 0);
      checkOutput("rst_jump_press", jump_press, 0);
      checkOutput("rst_proto_err", proto_err, 0);
      rst = 1'b0;
      repeat (10) @(negedge clk);

      // Cycle-exact capture and event latency for a single jump make
      pushEvent(8'h29, 1'b0, 1'b0, 1'b1, 1'b1);
      received_data = 8'h29;
      received      = 1'b1;
      repeat (SYNC) @(posedge clk);
      #1 checkOutput("ack_before_capture", read_ack, 0);
      @(posedge clk);
      #1 checkOutput("ack_at_capture", read_ack, 1);
      checkOutput("valid_at_capture", key_valid, 0);
      @(posedge clk);
      #1 checkOutput("valid_after_decode", key_valid, 1);
      @(posedge clk);
      #1 checkOutput("valid_one_cycle", key_valid, 0);
      repeat (4) @(posedge clk);
      #1 checkOutput("ack_held", read_ack, 1);
      @(negedge clk);
      received = 1'b0;
      repeat (SYNC) @(posedge clk);
      #1 checkOutput("ack_before_fall", read_ack, 1);
      @(posedge clk);
      #1 checkOutput("ack_after_fall", read_ack, 0);
      repeat (3) @(negedge clk);

      // Typematic repeat of a held jump key, then release and fresh press
      pushEvent(8'h29, 1'b0, 1'b0, 1'b0, 1'b1);
      applyStimulus(8'h29);
      pushEvent(8'h29, 1'b0, 1'b0, 1'b0, 1'b1);
      applyStimulus(8'h29);
      applyStimulus(8'hF0);
      pushEvent(8'h29, 1'b0, 1'b1, 1'b0, 1'b0);
      applyStimulus(8'h29);
      pushEvent(8'h29, 1'b0, 1'b0, 1'b1, 1'b1);
      applyStimulus(8'h29);
      applyStimulus(8'hF0);
      pushEvent(8'h29, 1'b0, 1'b1, 1'b0, 1'b0);
      applyStimulus(8'h29);

      // Extended make/break; extended 29 must leave jump tracking alone
      applyStimulus(8'hE0);
      pushEvent(8'h75, 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(8'h75);
      applyStimulus(8'hE0);
      applyStimulus(8'hF0);
      pushEvent(8'h75, 1'b1, 1'b1, 1'b0, 1'b0);
      applyStimulus(8'h75);
      applyStimulus(8'hE0);
      pushEvent(8'h29, 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(8'h29);
      applyStimulus(8'hE0);
      applyStimulus(8'hE0);
      pushEvent(8'h6B, 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(8'h6B);

      // Prefix timeout returns silently to IDLE
      applyStimulus(8'hE0);
      repeat (2 * TMO) @(negedge clk);
      pushEvent(8'h1C, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(8'h1C);

      // Protocol errors and ignored codes
      applyStimulus(8'hF0);
      pushErr();
      applyStimulus(8'hF0);
      applyStimulus(8'hAA);
      applyStimulus(8'hFA);
      pushErr();
      applyStimulus(8'h00);
      pushErr();
      applyStimulus(8'hFF);
      applyStimulus(8'hE0);
      pushErr();
      applyStimulus(8'h00);
      applyStimulus(8'hE0);
      applyStimulus(8'hF0);
      pushErr();
      applyStimulus(8'hE0);
      pushEvent(8'h1C, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(8'h1C);

      // Reset mid-sequence abandons the E0 prefix
      applyStimulus(8'hE0);
      doReset(2);
      repeat (8) @(negedge clk);
      pushEvent(8'h75, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(8'h75);

      // received held high across reset release must not be captured
      @(negedge clk);
      received_data = 8'h29;
      received      = 1'b1;
      doReset(3);
      repeat (12) @(negedge clk);
      checkOutput("no_capture_ack", read_ack, 0);
      checkOutput("no_capture_held", jump_held, 0);
      received = 1'b0;
      repeat (6) @(negedge clk);
      pushEvent(8'h29, 1'b0, 1'b0, 1'b1, 1'b1);
      applyStimulus(8'h29);

      repeat (5) @(negedge clk);
      checkOutput("queue_drained", expQ.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
